// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch responder: FSM encoding and
// the instruction substituted for faulting fetches.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // RISC-V canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_ram.sv
// Instruction memory: one synchronous write port for program load and one
// registered read port; a same-word read/write in one cycle returns old data.
module instr_ram #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
    input  logic [31:0]                    wr_data,
    input  logic                           rd_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr,
    output logic [31:0]                    rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset so the loaded program survives a core
    // reset and the storage can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fetch_responder.sv
// Fetch responder: accepts one instruction fetch, waits WAIT_STATES cycles,
// returns the word from instr_ram. Define IFETCH_FAULT_CHECK_EN for fault checks.
module instr_fetch_responder
    import ifetch_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    input  logic [31:0]                    req_addr,
    output logic                           req_ready,
    input  logic                           flush,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_instr,
    output logic [31:0]                    rsp_addr,
    output logic                           rsp_fault,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] addr_q;
    logic [31:0] src_addr;
    logic [31:0] ram_data;
    logic        accept;
    logic        enter_resp;
    logic        fault_d;
    logic        fault_q;

    assign accept   = (state == IDLE) && req_valid && !flush;
    // With zero wait states the read is launched straight from the request.
    assign src_addr = (state == IDLE) ? req_addr : addr_q;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // through the case can leave a latch behind.
        state_next = state;
        cnt_next   = cnt;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (WAIT_STATES == 0) begin
                            state_next = RESP;
                        end else begin
                            state_next = WAIT;
                            cnt_next   = WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    cnt_next = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_next = RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign enter_resp = (state_next == RESP) && (state != RESP);

`ifdef IFETCH_FAULT_CHECK_EN
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    assign fault_d = (src_addr[1:0] != 2'b00) || (src_addr >= ADDR_LIMIT);
`else
    assign fault_d = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_addr <= '0;
            fault_q  <= 1'b0;
        end else if (enter_resp) begin
            rsp_addr <= src_addr;
            fault_q  <= fault_d;
        end
    end

    instr_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (enter_resp),
        .rd_addr (src_addr[AW+1:2]),
        .rd_data (ram_data)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_fault = fault_q;
    assign rsp_instr = fault_q ? NOP_INSTR : ram_data;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Self-checking bench for instr_fetch_responder: a WAIT_STATES=2 instance
// for most scenarios and a WAIT_STATES=0 instance for the zero-wait latency.
module tb_instr_fetch_responder;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        fault;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_valid_b = 1'b0;
    logic        flush = 1'b0, rsp_ready = 1'b0, load_en = 1'b0;
    logic [31:0] req_addr = '0, load_data = '0;
    logic [7:0]  load_addr = '0;
    logic        req_ready, rsp_valid, rsp_fault;
    logic [31:0] rsp_instr, rsp_addr;
    logic        req_ready_b, rsp_valid_b, rsp_fault_b;
    logic [31:0] rsp_instr_b, rsp_addr_b;

    logic [31:0] model_mem [256];
    rsp_t        sb [$];
    rsp_t        exp;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;
    bit          seen;

    always #5 clk = ~clk;

    instr_fetch_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
        .rsp_fault(rsp_fault), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data)
    );

    instr_fetch_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_addr(req_addr),
        .req_ready(req_ready_b), .flush(flush), .rsp_valid(rsp_valid_b),
        .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_b), .rsp_addr(rsp_addr_b),
        .rsp_fault(rsp_fault_b), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data)
    );

    function automatic rsp_t model(input logic [31:0] a);
        rsp_t r;
        r.addr = a;
`ifdef IFETCH_FAULT_CHECK_EN
        r.fault = (a[1:0] != 2'b00) || (a >= 32'd1024);
`else
        r.fault = 1'b0;
`endif
        r.instr = r.fault ? 32'h0000_0013 : model_mem[a[9:2]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        load_en = 1'b1; load_addr = 8'(idx); load_data = d;
        model_mem[idx] = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] a);
        req_addr = a; req_valid = 1'b1;
        sb.push_back(model(a));
        tick();
        req_valid = 1'b0;
    endtask

    // Edges counted from the one that accepted the request.
    task automatic wait_valid(input bit use_b, output int l);
        l = 1;
        while (!(use_b ? rsp_valid_b : rsp_valid) && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({rsp_valid, req_ready, rsp_fault, rsp_instr, rsp_addr} !== {1'b0, 1'b1, 1'b0, 64'h0}) begin
            n_err++;
            $display("FAIL reset_a: got v=%b rdy=%b f=%b i=%h a=%h want 0/1/0/0/0",
                     rsp_valid, req_ready, rsp_fault, rsp_instr, rsp_addr);
        end
        n_cmp++;
        if ({rsp_valid_b, req_ready_b, rsp_fault_b, rsp_instr_b, rsp_addr_b} !== {1'b0, 1'b1, 1'b0, 64'h0}) begin
            n_err++;
            $display("FAIL reset_b: got v=%b rdy=%b f=%b i=%h a=%h want 0/1/0/0/0",
                     rsp_valid_b, req_ready_b, rsp_fault_b, rsp_instr_b, rsp_addr_b);
        end
        @(negedge clk) reset = 1'b0;
        tick();
        load_word(0, 32'h1111_0000);
        load_word(1, 32'hDEAD_BEEF);
        for (int i = 2; i < 8; i++) load_word(i, 32'h0101_0101 * i + 32'hA000_0000);
    endtask

    task automatic test_basic();
        send_req(32'h4);
        wait_valid(1'b0, lat);
        n_cmp++;
        if (lat !== 3) begin n_err++; $display("FAIL basic_latency: got %0d want 3", lat); end
        exp = sb.pop_front();
        n_cmp++;
        if ({rsp_instr, rsp_addr, rsp_fault} !== {32'hDEAD_BEEF, 32'h4, 1'b0}) begin
            n_err++;
            $display("FAIL basic_data: got %h/%h/%b want deadbeef/00000004/0", rsp_instr, rsp_addr, rsp_fault);
        end
        n_cmp++;
        if ({rsp_instr, rsp_addr, rsp_fault} !== exp) begin
            n_err++;
            $display("FAIL basic_sb: got %h/%h/%b want %h/%h/%b",
                     rsp_instr, rsp_addr, rsp_fault, exp.instr, exp.addr, exp.fault);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        send_req(32'hC);
        wait_valid(1'b0, lat);
        n_cmp++;
        if (lat !== 3) begin n_err++; $display("FAIL bp_latency: got %0d want 3", lat); end
        exp = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rsp_valid, req_ready, rsp_instr, rsp_addr, rsp_fault} !== {1'b1, 1'b0, exp}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b %h/%h/%b want 1/0 %h/%h/%b", i,
                         rsp_valid, req_ready, rsp_instr, rsp_addr, rsp_fault, exp.instr, exp.addr, exp.fault);
            end
            tick();
        end
        handshake();
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_idle: got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_flush();
        send_req(32'h10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        void'(sb.pop_back());
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= rsp_valid;
            tick();
        end
        n_cmp++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_wait: got seen_valid=%b rdy=%b want 0/1", seen, req_ready);
        end
        send_req(32'h8);
        wait_valid(1'b0, lat);
        exp = sb.pop_front();
        n_cmp++;
        if (lat !== 3 || {rsp_instr, rsp_addr, rsp_fault} !== exp) begin
            n_err++;
            $display("FAIL flush_next: got lat=%0d %h/%h want lat=3 %h/%h", lat, rsp_instr, rsp_addr, exp.instr, exp.addr);
        end
        handshake();
        // Flush while a response is presented, then flush racing a request in IDLE.
        send_req(32'h18);
        wait_valid(1'b0, lat);
        void'(sb.pop_front());
        flush = 1'b1;
        tick();
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_resp: got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
        end
        req_valid = 1'b1; req_addr = 32'h1C;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= rsp_valid | ~req_ready;
            tick();
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle_req: got accepted=%b want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        send_req(32'h4);
        wait_valid(1'b0, lat);
        exp = sb.pop_front();
        req_valid = 1'b1; req_addr = 32'h8; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_no_accept: got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
        end
        sb.push_back(model(32'h8));
        tick();
        req_valid = 1'b0;
        wait_valid(1'b0, lat);
        exp = sb.pop_front();
        n_cmp++;
        if (lat !== 3 || {rsp_instr, rsp_addr, rsp_fault} !== exp) begin
            n_err++;
            $display("FAIL b2b_next: got lat=%0d %h/%h want lat=3 %h/%h", lat, rsp_instr, rsp_addr, exp.instr, exp.addr);
        end
        handshake();
    endtask

    task automatic test_collision();
        send_req(32'h14);
        tick();
        load_en = 1'b1; load_addr = 8'd5; load_data = 32'hC0FF_EE55;
        tick();
        load_en = 1'b0;
        exp = sb.pop_front();
        model_mem[5] = 32'hC0FF_EE55;
        n_cmp++;
        if ({rsp_valid, rsp_instr, rsp_addr, rsp_fault} !== {1'b1, exp}) begin
            n_err++;
            $display("FAIL collide_old: got v=%b %h want 1 %h", rsp_valid, rsp_instr, exp.instr);
        end
        handshake();
        send_req(32'h14);
        wait_valid(1'b0, lat);
        exp = sb.pop_front();
        n_cmp++;
        if (rsp_instr !== exp.instr || rsp_instr !== 32'hC0FF_EE55) begin
            n_err++;
            $display("FAIL collide_new: got %h want c0ffee55", rsp_instr);
        end
        handshake();
    endtask

    task automatic test_fault();
        logic [31:0] addrs [2];
        addrs[0] = 32'h6;
        addrs[1] = 32'h400;
        for (int i = 0; i < 2; i++) begin
            send_req(addrs[i]);
            wait_valid(1'b0, lat);
            exp = sb.pop_front();
            n_cmp++;
            if (lat !== 3 || {rsp_instr, rsp_addr, rsp_fault} !== exp) begin
                n_err++;
                $display("FAIL fault_%h: got lat=%0d %h/%h/%b want lat=3 %h/%h/%b", addrs[i], lat,
                         rsp_instr, rsp_addr, rsp_fault, exp.instr, exp.addr, exp.fault);
            end
            handshake();
        end
    endtask

    task automatic test_reset_mid_wait();
        send_req(32'h4);
        #2 reset = 1'b1;
        #1;
        void'(sb.pop_back());
        n_cmp++;
        if ({rsp_valid, req_ready, rsp_fault, rsp_instr, rsp_addr} !== {1'b0, 1'b1, 1'b0, 64'h0}) begin
            n_err++;
            $display("FAIL reset_mid_wait: got v=%b rdy=%b f=%b i=%h a=%h want 0/1/0/0/0",
                     rsp_valid, req_ready, rsp_fault, rsp_instr, rsp_addr);
        end
        @(negedge clk) reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= rsp_valid;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL reset_discard: got valid=%b want 0", seen); end
        send_req(32'h8);
        wait_valid(1'b0, lat);
        exp = sb.pop_front();
        n_cmp++;
        if (lat !== 3 || {rsp_instr, rsp_addr, rsp_fault} !== exp) begin
            n_err++;
            $display("FAIL reset_after: got lat=%0d %h want lat=3 %h (memory kept)", lat, rsp_instr, exp.instr);
        end
        handshake();
    endtask

    task automatic test_zero_wait();
        req_addr = 32'h4; req_valid_b = 1'b1;
        exp = model(32'h4);
        tick();
        req_valid_b = 1'b0;
        wait_valid(1'b1, lat);
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL zw_latency: got %0d want 1", lat); end
        n_cmp++;
        if ({rsp_instr_b, rsp_addr_b, rsp_fault_b} !== exp) begin
            n_err++;
            $display("FAIL zw_data: got %h/%h/%b want %h/%h/%b",
                     rsp_instr_b, rsp_addr_b, rsp_fault_b, exp.instr, exp.addr, exp.fault);
        end
        handshake();
        n_cmp++;
        if ({rsp_valid_b, req_ready_b} !== 2'b01) begin
            n_err++;
            $display("FAIL zw_idle: got v=%b rdy=%b want 0/1", rsp_valid_b, req_ready_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_collision();
        test_fault();
        test_reset_mid_wait();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
